// File: rtl/ex_mem_stage_if.sv
// EX->stage->MEM bundle: EX request side, MEM presentation side and branch resolution.
// The stage itself uses the slave modport; the EX/MEM environment uses master.
interface ex_mem_stage_if #(
  parameter int DW = 16,
  parameter int RW = 3
);
  logic          ex_valid;
  logic          ex_ready;
  logic [DW-1:0] alu_result;
  logic          alu_zero;
  logic [RW-1:0] ex_rd;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic [DW-1:0] ex_store_data;
  logic          ex_beq;
  logic          ex_bne;
  logic [DW-1:0] ex_branch_target;

  logic          mem_valid;
  logic          mem_ready;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [RW-1:0] mem_rd;
  logic          mem_reg_write;
  logic          mem_mem_read;
  logic          mem_mem_write;
  logic          branch_taken;
  logic [DW-1:0] branch_target;

  modport slave (
    input  ex_valid, alu_result, alu_zero, ex_rd, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_store_data, ex_beq, ex_bne, ex_branch_target, mem_ready,
    output ex_ready, mem_valid, mem_addr, mem_wdata, mem_rd, mem_reg_write,
           mem_mem_read, mem_mem_write, branch_taken, branch_target
  );

  modport master (
    output ex_valid, alu_result, alu_zero, ex_rd, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_store_data, ex_beq, ex_bne, ex_branch_target, mem_ready,
    input  ex_ready, mem_valid, mem_addr, mem_wdata, mem_rd, mem_reg_write,
           mem_mem_read, mem_mem_write, branch_taken, branch_target
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with one-entry skid: 1-cycle latency, ex_ready depends only on skid state.
// Branches resolve at accept into a one-cycle pulse; EX_MEM_STALL_CNT_EN adds a saturating stall counter.
module ex_mem_stage #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  ex_mem_stage_if.slave  bus
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [15:0]    stall_cnt
`endif
);

  typedef struct packed {
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [RW-1:0] rd;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
  } entry_t;

  entry_t        out_q, out_d;
  entry_t        skid_q, skid_d;
  entry_t        in_ent;
  logic          mem_valid_q, mem_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic          br_taken_q, br_taken_d;
  logic [DW-1:0] br_target_q, br_target_d;

  logic accept;
  logic out_free;
  logic taken;

  assign accept   = bus.ex_valid & ~skid_valid_q;
  assign out_free = ~mem_valid_q | bus.mem_ready;
  assign taken    = (bus.ex_beq & bus.alu_zero) | (bus.ex_bne & ~bus.alu_zero);

  always_comb begin
    in_ent           = '0;
    in_ent.addr      = bus.alu_result;
    in_ent.wdata     = bus.ex_store_data;
    in_ent.rd        = bus.ex_rd;
    in_ent.reg_write = bus.ex_reg_write;
    in_ent.mem_read  = bus.ex_mem_read;
    in_ent.mem_write = bus.ex_mem_write;
  end

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    mem_valid_d  = mem_valid_q;
    skid_valid_d = skid_valid_q;
    br_taken_d   = 1'b0;
    br_target_d  = br_target_q;
    if (flush) begin
      mem_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      // Skid always drains first so program order survives a stall.
      if (out_free) begin
        if (skid_valid_q) begin
          out_d        = skid_q;
          mem_valid_d  = 1'b1;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          out_d       = in_ent;
          mem_valid_d = 1'b1;
        end else begin
          mem_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_d       = in_ent;
        skid_valid_d = 1'b1;
      end
      if (accept && taken) begin
        br_taken_d  = 1'b1;
        br_target_d = bus.ex_branch_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q        <= '0;
      skid_q       <= '0;
      mem_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      br_taken_q   <= 1'b0;
      br_target_q  <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      mem_valid_q  <= mem_valid_d;
      skid_valid_q <= skid_valid_d;
      br_taken_q   <= br_taken_d;
      br_target_q  <= br_target_d;
    end
  end

  assign bus.ex_ready      = ~skid_valid_q;
  assign bus.mem_valid     = mem_valid_q;
  assign bus.mem_addr      = out_q.addr;
  assign bus.mem_wdata     = out_q.wdata;
  assign bus.mem_rd        = out_q.rd;
  assign bus.mem_reg_write = out_q.reg_write;
  assign bus.mem_mem_read  = out_q.mem_read;
  assign bus.mem_mem_write = out_q.mem_write;
  assign bus.branch_taken  = br_taken_q;
  assign bus.branch_target = br_target_q;

`ifdef EX_MEM_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Flush does not clear this: it measures MEM back-pressure over the whole run.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (mem_valid_q && !bus.mem_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboarded bench for ex_mem_stage: directed scenarios followed by randomized traffic.
// The model is a queue of instructions held by the stage plus a next-cycle branch expectation.
module tb_ex_mem_stage;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [2:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
`ifdef EX_MEM_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  ex_mem_stage_if #(.DW(16), .RW(3)) bus ();

  ex_mem_stage #(.DW(16), .RW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
`ifdef EX_MEM_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  ent_t        exp_q[$];
  logic        mon_en = 1'b0;
  logic        pend_vld = 1'b0;
  ent_t        pend;
  logic        prev_fl = 1'b0;
  logic        br_exp_nxt = 1'b0, br_exp_cur = 1'b0;
  logic [15:0] tgt_exp_nxt = '0, tgt_exp_cur = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [15:0] a);
    ent_t e;
    e.addr  = a;
    e.wdata = a ^ 16'h5A5A;
    e.rd    = a[6:4];
    e.rw    = a[4];
    e.mr    = a[5];
    e.mw    = a[6];
    return e;
  endfunction

  // One clock of stimulus; the model advances on the edge the stage commits on.
  task automatic step(input logic v, input ent_t e, input logic beq, input logic bne,
                      input logic z, input logic [15:0] tgt, input logic rdy, input logic fl);
    logic acc;
    logic tk;
    bus.ex_valid         = v;
    bus.alu_result       = e.addr;
    bus.ex_store_data    = e.wdata;
    bus.ex_rd            = e.rd;
    bus.ex_reg_write     = e.rw;
    bus.ex_mem_read      = e.mr;
    bus.ex_mem_write     = e.mw;
    bus.ex_beq           = beq;
    bus.ex_bne           = bne;
    bus.alu_zero         = z;
    bus.ex_branch_target = tgt;
    bus.mem_ready        = rdy;
    flush                = fl;
    acc      = v && (exp_q.size() < 2);
    tk       = (beq && z) || (bne && !z);
    pend_vld = acc && !fl;
    pend     = e;
    br_exp_nxt = acc && !fl && tk;
    if (br_exp_nxt) tgt_exp_nxt = tgt;
    prev_fl = fl;
    @(posedge clk);
    #1;
    if (prev_fl) exp_q.delete();
    else if (pend_vld) exp_q.push_back(pend);
    pend_vld    = 1'b0;
    br_exp_cur  = br_exp_nxt;
    tgt_exp_cur = tgt_exp_nxt;
    chk("ex_ready", 64'(bus.ex_ready), 64'(exp_q.size() < 2));
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, mk(16'h0), 1'b0, 1'b0, 1'b0, 16'h0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    flush  = 1'b0;
    bus.ex_valid = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    br_exp_nxt = 1'b0; br_exp_cur = 1'b0;
    tgt_exp_nxt = '0;  tgt_exp_cur = '0;
    prev_fl = 1'b0;
    chk("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("rst_branch_taken", 64'(bus.branch_taken), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_ctrl", 64'({bus.mem_rd, bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write}), 64'd0);
    chk("rst_branch_target", 64'(bus.branch_target), 64'd0);
    chk("rst_ex_ready", 64'(bus.ex_ready), 64'd1);
    mon_en = 1'b1;
  endtask

  // Monitor: mid-cycle, compares presentation and pops on each MEM handshake.
  initial begin
    ent_t got;
    ent_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("mem_valid", 64'(bus.mem_valid), 64'(exp_q.size() > 0));
        chk("branch_taken", 64'(bus.branch_taken), 64'(br_exp_cur));
        chk("branch_target", 64'(bus.branch_target), 64'(tgt_exp_cur));
        if (bus.mem_valid && bus.mem_ready) begin
          got.addr  = bus.mem_addr;
          got.wdata = bus.mem_wdata;
          got.rd    = bus.mem_rd;
          got.rw    = bus.mem_reg_write;
          got.mr    = bus.mem_mem_read;
          got.mw    = bus.mem_mem_write;
          if (exp_q.size() == 0) begin
            chk("unexpected_drain", 64'(got), 64'(0));
            miscompares++;
            $display("FAIL drain_with_empty_model at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("mem_entry", 64'(got), 64'(e));
          end
        end
      end
    end
  end

  initial begin
    ent_t r;
    do_reset();

    // Streaming at full rate.
    for (int i = 1; i <= 4; i++) step(1'b1, mk(16'(i * 16)), 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Back-pressure: A in output, B in skid.
    step(1'b1, mk(16'h1111), 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, mk(16'h2222), 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    idle(1'b0);
    chk("stall_ex_ready", 64'(bus.ex_ready), 64'd0);
    chk("stall_mem_addr", 64'(bus.mem_addr), 64'h1111);
    repeat (3) idle(1'b1);

    // Branch resolution.
    step(1'b1, mk(16'h0030), 1'b1, 1'b0, 1'b1, 16'h00A4, 1'b1, 1'b0);
    chk("beq_taken", 64'(bus.branch_taken), 64'd1);
    chk("beq_target", 64'(bus.branch_target), 64'h00A4);
    step(1'b1, mk(16'h0040), 1'b0, 1'b1, 1'b1, 16'h0BAD, 1'b1, 1'b0);
    chk("bne_not_taken", 64'(bus.branch_taken), 64'd0);
    chk("target_held", 64'(bus.branch_target), 64'h00A4);
    step(1'b1, mk(16'h0050), 1'b1, 1'b1, 1'b0, 16'h0777, 1'b1, 1'b0);
    chk("beq_bne_taken", 64'(bus.branch_taken), 64'd1);
    idle(1'b1);

    // Flush with output and skid both occupied.
    step(1'b1, mk(16'h3333), 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, mk(16'h4444), 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, mk(16'h5555), 1'b1, 1'b0, 1'b1, 16'h0999, 1'b0, 1'b1);
    chk("flush_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("flush_ex_ready", 64'(bus.ex_ready), 64'd1);
    chk("flush_no_branch", 64'(bus.branch_taken), 64'd0);
    repeat (3) idle(1'b1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      r.addr  = 16'($urandom);
      r.wdata = 16'($urandom);
      r.rd    = 3'($urandom);
      r.rw    = 1'($urandom);
      r.mr    = 1'($urandom);
      r.mw    = 1'($urandom);
      step(1'($urandom_range(0, 3) != 0), r, 1'($urandom), 1'($urandom), 1'($urandom),
           16'($urandom), 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 29) == 0));
    end
    repeat (4) idle(1'b1);

`ifdef EX_MEM_STALL_CNT_EN
    do_reset();
    step(1'b1, mk(16'h6666), 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    repeat (5) idle(1'b0);
    chk("stall_cnt_5", 64'(stall_cnt), 64'd5);
    step(1'b0, mk(16'h0), 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    chk("stall_cnt_flush", 64'(stall_cnt), 64'd5);
    do_reset();
    chk("stall_cnt_reset", 64'(stall_cnt), 64'd0);
`endif

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
